// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding-select generation, load-use hazard
// detection and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              HOLD,
    input  logic              FLUSH,
    input  logic              ID_VALID,
    input  logic [31:0]       ID_RD1,
    input  logic [31:0]       ID_RD2,
    input  logic [31:0]       ID_IMM,
    input  logic [31:0]       ID_PC,
    input  logic [4:0]        ID_RS1,
    input  logic [4:0]        ID_RS2,
    input  logic [4:0]        ID_RD,
    input  logic              ID_MEMREAD,
    input  logic              ID_REGWRITE,
    input  logic [CTRL_W-1:0] ID_CTRL,
    input  logic [4:0]        EXMEM_RD,
    input  logic              EXMEM_REGWRITE,
    input  logic [4:0]        MEMWB_RD,
    input  logic              MEMWB_REGWRITE,
    output logic [31:0]       RD1,
    output logic [31:0]       RD2,
    output logic [31:0]       IMM,
    output logic [31:0]       PC,
    output logic [4:0]        RS1,
    output logic [4:0]        RS2,
    output logic [4:0]        RD,
    output logic              MEMREAD,
    output logic              REGWRITE,
    output logic              VALID,
    output logic [CTRL_W-1:0] CTRL,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              STALL,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  FLUSH_CNT
);

    logic [31:0]       rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic              memread_q, memread_d, regwrite_q, regwrite_d, valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic              lu_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // EX/MEM wins over MEM/WB; register 0 is never forwarded
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] em_rd, input logic em_rw,
                                           input logic [4:0] mw_rd, input logic mw_rw);
        if (em_rw && (em_rd != 5'd0) && (em_rd == src)) begin
            return 2'b10;
        end else if (mw_rw && (mw_rd != 5'd0) && (mw_rd == src)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign lu_s = valid_q & memread_q & (rd_q != 5'd0) & ID_VALID &
                  ((rd_q == ID_RS1) | (rd_q == ID_RS2));

    assign STALL    = lu_s & ~FLUSH & ~HOLD;
    assign ForwardA = fwd_sel(rs1_q, EXMEM_RD, EXMEM_REGWRITE, MEMWB_RD, MEMWB_REGWRITE);
    assign ForwardB = fwd_sel(rs2_q, EXMEM_RD, EXMEM_REGWRITE, MEMWB_RD, MEMWB_REGWRITE);

    // Next-state selection: hold, then flush bubble, then load-use bubble, then capture
    always_comb begin
        rd1_d = rd1_q;  rd2_d = rd2_q;  imm_d = imm_q;  pc_d = pc_q;
        rs1_d = rs1_q;  rs2_d = rs2_q;  rd_d  = rd_q;
        memread_d = memread_q;  regwrite_d = regwrite_q;  valid_d = valid_q;
        ctrl_d = ctrl_q;
        stall_cnt_d = stall_cnt_q;  flush_cnt_d = flush_cnt_q;
        if (HOLD) begin
            valid_d = valid_q;
        end else if (FLUSH || lu_s) begin
            // Bubble keeps operand data; only control and indices are cleared
            valid_d = 1'b0;  memread_d = 1'b0;  regwrite_d = 1'b0;
            ctrl_d  = {CTRL_W{1'b0}};
            rs1_d = 5'd0;  rs2_d = 5'd0;  rd_d = 5'd0;
            if (FLUSH) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
        end else begin
            rd1_d = ID_RD1;  rd2_d = ID_RD2;  imm_d = ID_IMM;  pc_d = ID_PC;
            rs1_d = ID_RS1;  rs2_d = ID_RS2;  rd_d  = ID_RD;
            memread_d = ID_MEMREAD;  regwrite_d = ID_REGWRITE;  valid_d = ID_VALID;
            ctrl_d = ID_CTRL;
        end
    end

    // Pipeline and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd1_q <= 32'd0;  rd2_q <= 32'd0;  imm_q <= 32'd0;  pc_q <= 32'd0;
            rs1_q <= 5'd0;   rs2_q <= 5'd0;   rd_q  <= 5'd0;
            memread_q <= 1'b0;  regwrite_q <= 1'b0;  valid_q <= 1'b0;
            ctrl_q <= {CTRL_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            rd1_q <= rd1_d;  rd2_q <= rd2_d;  imm_q <= imm_d;  pc_q <= pc_d;
            rs1_q <= rs1_d;  rs2_q <= rs2_d;  rd_q  <= rd_d;
            memread_q <= memread_d;  regwrite_q <= regwrite_d;  valid_q <= valid_d;
            ctrl_q <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign RD1 = rd1_q;  assign RD2 = rd2_q;  assign IMM = imm_q;  assign PC = pc_q;
    assign RS1 = rs1_q;  assign RS2 = rs2_q;  assign RD  = rd_q;
    assign MEMREAD = memread_q;  assign REGWRITE = regwrite_q;  assign VALID = valid_q;
    assign CTRL = ctrl_q;
    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        HOLD, FLUSH, ID_VALID, ID_MEMREAD, ID_REGWRITE;
    logic [31:0] ID_RD1, ID_RD2, ID_IMM, ID_PC;
    logic [4:0]  ID_RS1, ID_RS2, ID_RD, EXMEM_RD, MEMWB_RD;
    logic        EXMEM_REGWRITE, MEMWB_REGWRITE;
    logic [7:0]  ID_CTRL;

    logic [31:0] RD1, RD2, IMM, PC;
    logic [4:0]  RS1, RS2, RD;
    logic        MEMREAD, REGWRITE, VALID, STALL;
    logic [7:0]  CTRL;
    logic [1:0]  ForwardA, ForwardB;
    logic [15:0] STALL_CNT, FLUSH_CNT;

    logic [31:0] s_rd1, s_rd2, s_imm, s_pc;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic        s_memread, s_regwrite, s_valid, s_stall;
    logic [7:0]  s_ctrl;
    logic [1:0]  s_fwda, s_fwdb;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .HOLD(HOLD), .FLUSH(FLUSH), .ID_VALID(ID_VALID),
        .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_IMM(ID_IMM), .ID_PC(ID_PC),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
        .ID_MEMREAD(ID_MEMREAD), .ID_REGWRITE(ID_REGWRITE), .ID_CTRL(ID_CTRL),
        .EXMEM_RD(EXMEM_RD), .EXMEM_REGWRITE(EXMEM_REGWRITE),
        .MEMWB_RD(MEMWB_RD), .MEMWB_REGWRITE(MEMWB_REGWRITE),
        .RD1(RD1), .RD2(RD2), .IMM(IMM), .PC(PC), .RS1(RS1), .RS2(RS2), .RD(RD),
        .MEMREAD(MEMREAD), .REGWRITE(REGWRITE), .VALID(VALID), .CTRL(CTRL),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .STALL(STALL),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    id_ex_stage #(.CTRL_W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .HOLD(HOLD), .FLUSH(FLUSH), .ID_VALID(ID_VALID),
        .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_IMM(ID_IMM), .ID_PC(ID_PC),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
        .ID_MEMREAD(ID_MEMREAD), .ID_REGWRITE(ID_REGWRITE), .ID_CTRL(ID_CTRL),
        .EXMEM_RD(EXMEM_RD), .EXMEM_REGWRITE(EXMEM_REGWRITE),
        .MEMWB_RD(MEMWB_RD), .MEMWB_REGWRITE(MEMWB_REGWRITE),
        .RD1(s_rd1), .RD2(s_rd2), .IMM(s_imm), .PC(s_pc), .RS1(s_rs1), .RS2(s_rs2), .RD(s_rd),
        .MEMREAD(s_memread), .REGWRITE(s_regwrite), .VALID(s_valid), .CTRL(s_ctrl),
        .ForwardA(s_fwda), .ForwardB(s_fwdb), .STALL(s_stall),
        .STALL_CNT(s_stall_cnt), .FLUSH_CNT(s_flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        HOLD = 1'b0;  FLUSH = 1'b0;  ID_VALID = 1'b0;  ID_MEMREAD = 1'b0;  ID_REGWRITE = 1'b0;
        ID_RD1 = 32'd0;  ID_RD2 = 32'd0;  ID_IMM = 32'd0;  ID_PC = 32'd0;
        ID_RS1 = 5'd0;  ID_RS2 = 5'd0;  ID_RD = 5'd0;  ID_CTRL = 8'd0;
        EXMEM_RD = 5'd0;  EXMEM_REGWRITE = 1'b0;  MEMWB_RD = 5'd0;  MEMWB_REGWRITE = 1'b0;
    endtask

    task automatic present_load();
        ID_VALID = 1'b1;  ID_MEMREAD = 1'b1;  ID_REGWRITE = 1'b1;  ID_RD = 5'd7;
        ID_RS1 = 5'd1;  ID_RS2 = 5'd2;  ID_RD1 = 32'h0000_1111;  ID_CTRL = 8'h3C;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ID_VALID = 1'b1;  ID_MEMREAD = 1'b1;  ID_REGWRITE = 1'b1;  HOLD = 1'b0;  FLUSH = 1'b0;
        ID_RD1 = $urandom;  ID_RD2 = $urandom;  ID_IMM = $urandom;  ID_PC = $urandom;
        ID_RS1 = 5'($urandom);  ID_RS2 = 5'($urandom);  ID_RD = 5'($urandom);
        ID_CTRL = 8'($urandom);
        EXMEM_RD = 5'($urandom_range(1, 31));  EXMEM_REGWRITE = 1'b1;
        MEMWB_RD = 5'($urandom_range(1, 31));  MEMWB_REGWRITE = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({RD1, RD2, IMM, PC} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0", RD1, RD2, IMM, PC);
        end
        n_checks++;
        if ({RS1, RS2, RD, MEMREAD, REGWRITE, VALID, CTRL} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rs1=%0d rs2=%0d rd=%0d mr=%b rw=%b v=%b ctrl=%h expected 0",
                     RS1, RS2, RD, MEMREAD, REGWRITE, VALID, CTRL);
        end
        n_checks++;
        if ({ForwardA, ForwardB, STALL, STALL_CNT, FLUSH_CNT} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_fwd_cnt: got fa=%b fb=%b stall=%b sc=%0d fc=%0d expected 0",
                     ForwardA, ForwardB, STALL, STALL_CNT, FLUSH_CNT);
        end
        zero_inputs();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_pass_through();
        ID_VALID = 1'b1;  ID_RD1 = 32'h1234_5678;  ID_RD2 = 32'hCAFE_0001;  ID_RD = 5'd5;
        ID_IMM = 32'h0000_0ABC;  ID_PC = 32'h0000_0040;  ID_REGWRITE = 1'b1;  ID_CTRL = 8'hA5;
        step();
        n_checks++;
        if ({RD1, RD, VALID} !== {32'h1234_5678, 5'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL pass_through: got rd1=%h rd=%0d v=%b expected 12345678 5 1", RD1, RD, VALID);
        end
        n_checks++;
        if ({RD2, IMM, PC, CTRL, REGWRITE, MEMREAD} !== {32'hCAFE_0001, 32'h0000_0ABC, 32'h0000_0040, 8'hA5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pass_fields: got rd2=%h imm=%h pc=%h ctrl=%h rw=%b mr=%b", RD2, IMM, PC, CTRL, REGWRITE, MEMREAD);
        end
    endtask

    task automatic test_forward();
        ID_RS1 = 5'd3;  ID_RS2 = 5'd9;  ID_MEMREAD = 1'b0;
        step();
        EXMEM_RD = 5'd3;  EXMEM_REGWRITE = 1'b1;  MEMWB_RD = 5'd3;  MEMWB_REGWRITE = 1'b1;
        #1;
        n_checks++;
        if ({ForwardA, ForwardB} !== 4'b1000) begin
            n_fail++;
            $display("FAIL fwd_priority: got fa=%b fb=%b expected 10 00", ForwardA, ForwardB);
        end
        EXMEM_REGWRITE = 1'b0;
        #1;
        n_checks++;
        if (ForwardA !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_memwb: got %b expected 01", ForwardA);
        end
        EXMEM_RD = 5'd9;  EXMEM_REGWRITE = 1'b1;  MEMWB_RD = 5'd9;
        #1;
        n_checks++;
        if ({ForwardA, ForwardB} !== 4'b0010) begin
            n_fail++;
            $display("FAIL fwd_b_exmem: got fa=%b fb=%b expected 00 10", ForwardA, ForwardB);
        end
        ID_RS1 = 5'd0;  ID_RS2 = 5'd0;
        step();
        EXMEM_RD = 5'd0;  MEMWB_RD = 5'd0;
        #1;
        n_checks++;
        if ({ForwardA, ForwardB} !== 4'b0000) begin
            n_fail++;
            $display("FAIL fwd_zero_reg: got fa=%b fb=%b expected 00 00", ForwardA, ForwardB);
        end
        EXMEM_REGWRITE = 1'b0;  MEMWB_REGWRITE = 1'b0;
    endtask

    task automatic test_load_use();
        present_load();
        step();
        ID_MEMREAD = 1'b0;  ID_RD = 5'd8;  ID_RS1 = 5'd4;  ID_RS2 = 5'd7;
        ID_RD1 = 32'h0000_2222;  ID_CTRL = 8'h11;
        #1;
        n_checks++;
        if (STALL !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall: got %b expected 1", STALL);
        end
        step();
        n_checks++;
        if ({VALID, MEMREAD, REGWRITE, RD, RS1, RS2, CTRL, STALL, STALL_CNT} !== {3'b000, 15'd0, 8'd0, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL lu_bubble: got v=%b mr=%b rw=%b rd=%0d ctrl=%h stall=%b sc=%0d expected bubble, sc=1",
                     VALID, MEMREAD, REGWRITE, RD, CTRL, STALL, STALL_CNT);
        end
        n_checks++;
        if (RD1 !== 32'h0000_1111) begin
            n_fail++;
            $display("FAIL lu_bubble_data: got %h expected 00001111", RD1);
        end
        MEMWB_RD = 5'd7;  MEMWB_REGWRITE = 1'b1;
        step();
        n_checks++;
        if ({VALID, RD, RS2, RD1, ForwardA, ForwardB} !== {1'b1, 5'd8, 5'd7, 32'h0000_2222, 2'b00, 2'b01}) begin
            n_fail++;
            $display("FAIL lu_resume: got v=%b rd=%0d rs2=%0d rd1=%h fa=%b fb=%b expected 1 8 7 00002222 00 01",
                     VALID, RD, RS2, RD1, ForwardA, ForwardB);
        end
        MEMWB_RD = 5'd0;  MEMWB_REGWRITE = 1'b0;
    endtask

    task automatic test_flush_hold();
        present_load();
        step();
        ID_MEMREAD = 1'b0;  ID_RD = 5'd8;  ID_RS1 = 5'd7;  ID_RS2 = 5'd0;  FLUSH = 1'b1;
        #1;
        n_checks++;
        if (STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_lu_stall: got %b expected 0", STALL);
        end
        step();
        FLUSH = 1'b0;
        n_checks++;
        if ({VALID, RD, FLUSH_CNT, STALL_CNT} !== {1'b0, 5'd0, 16'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL flush_lu_bubble: got v=%b rd=%0d fc=%0d sc=%0d expected 0 0 1 1",
                     VALID, RD, FLUSH_CNT, STALL_CNT);
        end
        present_load();
        step();
        ID_MEMREAD = 1'b0;  ID_RD = 5'd8;  ID_RS1 = 5'd7;  HOLD = 1'b1;  FLUSH = 1'b1;
        #1;
        n_checks++;
        if (STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stall: got %b expected 0", STALL);
        end
        step();
        n_checks++;
        if ({VALID, MEMREAD, RD, FLUSH_CNT, STALL_CNT} !== {1'b1, 1'b1, 5'd7, 16'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL hold_flush: got v=%b mr=%b rd=%0d fc=%0d sc=%0d expected 1 1 7 1 1",
                     VALID, MEMREAD, RD, FLUSH_CNT, STALL_CNT);
        end
        HOLD = 1'b0;  FLUSH = 1'b0;
        #1;
        n_checks++;
        if (STALL !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release_stall: got %b expected 1", STALL);
        end
    endtask

    task automatic test_reset_mid_stall();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({STALL, VALID, MEMREAD, RD, STALL_CNT, FLUSH_CNT} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got stall=%b v=%b mr=%b rd=%0d sc=%0d fc=%0d expected 0",
                     STALL, VALID, MEMREAD, RD, STALL_CNT, FLUSH_CNT);
        end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_saturation();
        zero_inputs();
        ID_VALID = 1'b1;  ID_MEMREAD = 1'b1;  ID_RD = 5'd7;  ID_RS1 = 5'd7;
        repeat (40) step();
        n_checks++;
        if ({s_stall_cnt, STALL_CNT} !== {4'd15, 16'd20}) begin
            n_fail++;
            $display("FAIL sat_reach: got small=%0d wide=%0d expected 15 20", s_stall_cnt, STALL_CNT);
        end
        repeat (4) step();
        n_checks++;
        if ({s_stall_cnt, STALL_CNT} !== {4'd15, 16'd22}) begin
            n_fail++;
            $display("FAIL sat_hold: got small=%0d wide=%0d expected 15 22", s_stall_cnt, STALL_CNT);
        end
    endtask

    initial begin
        zero_inputs();
        test_reset();
        test_pass_through();
        test_forward();
        test_load_use();
        test_flush_hold();
        test_reset_mid_stall();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated forwarding-select generation and load-use hazard detection for the 5-stage pipelined CPU. It captures decoded operands and control from ID and presents them to EX. It drives the `RD1`/`RD2` and `ForwardA`/`ForwardB` inputs of the EX-stage forwarding mux. It also raises `STALL` to freeze PC and IF/ID, and inserts a bubble whenever a load in EX feeds the instruction in ID.

## Interface
- `CTRL_W`, 8 — width of the opaque EX/MEM/WB control bundle passed through.
- `CNT_W`, 16 — width of the saturating stall/flush event counters.
- `clk` input 1 — single clock, rising edge.
- `reset_n` input 1 — reset; asynchronous, active-low.
- `HOLD` input 1 — global pipeline freeze (memory wait); register contents unchanged.
- `FLUSH` input 1 — taken branch/jump resolved in EX; kills the instruction entering EX.
- `ID_VALID` input 1 — ID holds a real instruction.
- `ID_RD1`, `ID_RD2`, `ID_IMM`, `ID_PC` input 32 each — register-file reads, immediate, PC.
- `ID_RS1`, `ID_RS2`, `ID_RD` input 5 each — source and destination register indices.
- `ID_MEMREAD`, `ID_REGWRITE` input 1 each — load and write-back flags.
- `ID_CTRL` input `CTRL_W` — remaining control.
- `EXMEM_RD` input 5, `EXMEM_REGWRITE` input 1 — destination of the instruction in MEM.
- `MEMWB_RD` input 5, `MEMWB_REGWRITE` input 1 — destination of the instruction in WB.
- `RD1`, `RD2`, `IMM`, `PC` output 32 — registered EX operands.
- `RS1`, `RS2`, `RD` output 5; `MEMREAD`, `REGWRITE`, `VALID` output 1; `CTRL` output `CTRL_W` — registered EX fields.
- `ForwardA`, `ForwardB` output 2 — mux selects: 00 = register file, 01 = WB result, 10 = EX/MEM ALU result.
- `STALL` output 1 — hold PC and IF/ID this cycle.
- `STALL_CNT`, `FLUSH_CNT` output `CNT_W` — saturating event counters.

## Operation
- Load-use (combinational): `LU` = `VALID` & `MEMREAD` & (`RD`≠0) & `ID_VALID` & (`RD`==`ID_RS1` | `RD`==`ID_RS2`).
- `STALL` = `LU` & ~`FLUSH` & ~`HOLD`. A flush kills the ID instruction, so no stall is raised for it.
- Register update priority at each clock edge:
  1. `HOLD`=1: all registers and counters keep their values.
  2. `FLUSH`=1: load a bubble; `FLUSH_CNT`++.
  3. `LU`=1: load a bubble; `STALL_CNT`++.
  4. Otherwise: capture all `ID_*` fields; `VALID`←`ID_VALID`.
- Bubble contents: `VALID`, `MEMREAD`, `REGWRITE` = 0; `CTRL`, `RS1`, `RS2`, `RD` = 0; `RD1`/`RD2`/`IMM`/`PC` keep their previous values.
- Forwarding is combinational from the registered fields, evaluated for X∈{A,B} with S = `RS1` (for A) or `RS2` (for B):
  - `EXMEM_REGWRITE` & `EXMEM_RD`≠0 & `EXMEM_RD`==S → 10.
  - Else `MEMWB_REGWRITE` & `MEMWB_RD`≠0 & `MEMWB_RD`==S → 01.
  - Else → 00.
  - EX/MEM has priority over MEM/WB when both match. Encoding 11 is never produced.
- Counters saturate at all-ones and never wrap. They are cleared only by reset.

## Timing
- Reset (asynchronous assert, released on a clock edge): all registered outputs are 0 and the counters are 0. `STALL`=0 and `ForwardA`/`ForwardB`=00 follow from these zeroed fields.
- Latency: an ID field presented in cycle n appears on the outputs in cycle n+1.
- `STALL`, `ForwardA` and `ForwardB` are valid in the same cycle as their inputs, with no registered delay.
- Load-use costs exactly one bubble. In the cycle after a stall the load has left EX, so `LU`=0. The held ID instruction is then captured, and `ForwardX`=01 supplies the load data from WB.
- `FLUSH` and `LU` in the same cycle: exactly one bubble is inserted. `FLUSH_CNT` increments, `STALL_CNT` does not, and `STALL`=0.
- `HOLD` together with `FLUSH` or `LU`: HOLD wins. There is no update and no count, and EX re-evaluates on the next non-held cycle.
- `reset_n` asserted mid-stall clears everything immediately. `STALL` drops in the same cycle.

## Test plan
- Reset: drive `reset_n`=0 with random inputs → all outputs 0, `ForwardA`/`ForwardB`=00, `STALL`=0, counters 0.
- Pass-through: `ID_RD1`=0x1234_5678, `ID_RD`=5, `ID_VALID`=1 → next cycle `RD1`=0x1234_5678, `RD`=5, `VALID`=1.
- Forward priority: `RS1`=3, `EXMEM_RD`=3, `MEMWB_RD`=3, both REGWRITE=1 → `ForwardA`=10. With `EXMEM_REGWRITE`=0 → 01. With `RS1`=0 → 00.
- Load-use: EX holds a load with `RD`=7 and ID has `ID_RS2`=7 → `STALL`=1 for one cycle. Next cycle `VALID`=0 and `STALL_CNT`=1. The cycle after, the ID instruction enters EX; with `MEMWB_RD`=7 and `MEMWB_REGWRITE`=1, `ForwardB`=01.
- Flush plus load-use in the same cycle → `STALL`=0, bubble inserted, `FLUSH_CNT`=1, `STALL_CNT` unchanged. `HOLD`=1 with `FLUSH`=1 → outputs and counters unchanged.
- Saturation: with `CNT_W`=4, force 20 load-use events → `STALL_CNT`=15, and it stays at 15.
